// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between the command controller and its UART RX, register file,
// ALU and TX FIFO neighbours.
interface sys_cmd_ctrl_if #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned ALU_OUT_WIDTH = 16
);
   // UART receive side
   logic [DATA_WIDTH-1:0]    rx_data;
   logic                     rx_valid;
   // register file
   logic                     rf_wr_en;
   logic                     rf_rd_en;
   logic [ADDR_WIDTH-1:0]    rf_addr;
   logic [DATA_WIDTH-1:0]    rf_wr_data;
   logic [DATA_WIDTH-1:0]    rf_rd_data;
   logic                     rf_rd_valid;
   // ALU
   logic                     alu_en;
   logic [3:0]               alu_fun;
   logic                     clk_gate_en;
   logic [ALU_OUT_WIDTH-1:0] alu_out;
   logic                     alu_out_valid;
   // TX FIFO
   logic [DATA_WIDTH-1:0]    tx_data;
   logic                     tx_valid;
   logic                     tx_full;
   // error flag
   logic                     cmd_err;

   // controller side
   modport master (
      input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
      output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
      output tx_data, tx_valid, cmd_err
   );

   // environment side
   modport slave (
      output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
      input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
      input  tx_data, tx_valid, cmd_err
   );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Command controller: decodes UART command frames into register-file writes/reads
// and ALU operations, and returns read data / ALU results through the TX FIFO.
module sys_cmd_ctrl #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned ALU_OUT_WIDTH = 16
) (
   input  logic           ref_clk,
   input  logic           reset_n,
   sys_cmd_ctrl_if.master bus
);

   localparam int unsigned HI_WIDTH = ALU_OUT_WIDTH - DATA_WIDTH;

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
      ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
   } state_e;

   state_e                  state_q, state_d;
   logic                    rf_wr_en_q, rf_wr_en_d;
   logic                    rf_rd_en_q, rf_rd_en_d;
   logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
   logic                    alu_en_q, alu_en_d;
   logic [3:0]              alu_fun_q, alu_fun_d;
   logic                    clk_gate_en_q, clk_gate_en_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    tx_valid_q, tx_valid_d;
   logic                    cmd_err_q, cmd_err_d;
   logic [DATA_WIDTH-1:0]   alu_hi_q, alu_hi_d;
   logic                    rd_path_q, rd_path_d;
   logic                    tx_accept_c;

   // State and output registers; reset discards any partial frame
   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         rf_addr_q     <= '0;
         rf_wr_data_q  <= '0;
         alu_en_q      <= 1'b0;
         alu_fun_q     <= '0;
         clk_gate_en_q <= 1'b0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         cmd_err_q     <= 1'b0;
         alu_hi_q      <= '0;
         rd_path_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rf_wr_en_q    <= rf_wr_en_d;
         rf_rd_en_q    <= rf_rd_en_d;
         rf_addr_q     <= rf_addr_d;
         rf_wr_data_q  <= rf_wr_data_d;
         alu_en_q      <= alu_en_d;
         alu_fun_q     <= alu_fun_d;
         clk_gate_en_q <= clk_gate_en_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         cmd_err_q     <= cmd_err_d;
         alu_hi_q      <= alu_hi_d;
         rd_path_q     <= rd_path_d;
      end
   end

   // Next-state and next-output decode; strobes default low, data fields hold
   always_comb begin
      state_d       = state_q;
      rf_wr_en_d    = 1'b0;
      rf_rd_en_d    = 1'b0;
      alu_en_d      = 1'b0;
      cmd_err_d     = 1'b0;
      rf_addr_d     = rf_addr_q;
      rf_wr_data_d  = rf_wr_data_q;
      alu_fun_d     = alu_fun_q;
      clk_gate_en_d = clk_gate_en_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      alu_hi_d      = alu_hi_q;
      rd_path_d     = rd_path_q;
      tx_accept_c   = tx_valid_q && !bus.tx_full;

      case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               case (bus.rx_data)
                  CMD_WR:     state_d = WR_ADDR;
                  CMD_RD:     state_d = RD_ADDR;
                  CMD_ALU_OP: state_d = ALU_A;
                  CMD_ALU_NO: state_d = ALU_FUN;
                  default:    cmd_err_d = 1'b1;
               endcase
            end
         end
         WR_ADDR: begin
            if (bus.rx_valid) begin
               rf_addr_d = bus.rx_data[ADDR_WIDTH-1:0];
               state_d   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (bus.rx_valid) begin
               rf_wr_data_d = bus.rx_data;
               rf_wr_en_d   = 1'b1;
               state_d      = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.rx_valid) begin
               rf_addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
               rf_rd_en_d = 1'b1;
               state_d    = RD_WAIT;
            end
         end
         RD_WAIT: begin
            cmd_err_d = bus.rx_valid;
            if (bus.rf_rd_valid) begin
               tx_data_d  = bus.rf_rd_data;
               tx_valid_d = 1'b1;
               rd_path_d  = 1'b1;
               state_d    = TX_LO;
            end
         end
         ALU_A, ALU_B: begin
            // operands land in register-file locations 0 and 1
            if (bus.rx_valid) begin
               rf_addr_d    = (state_q == ALU_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
               rf_wr_data_d = bus.rx_data;
               rf_wr_en_d   = 1'b1;
               state_d      = (state_q == ALU_A) ? ALU_B : ALU_FUN;
            end
         end
         ALU_FUN: begin
            if (bus.rx_valid) begin
               alu_fun_d     = bus.rx_data[3:0];
               alu_en_d      = 1'b1;
               clk_gate_en_d = 1'b1;
               state_d       = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            cmd_err_d = bus.rx_valid;
            if (bus.alu_out_valid) begin
               tx_data_d     = bus.alu_out[DATA_WIDTH-1:0];
               alu_hi_d      = DATA_WIDTH'(bus.alu_out[ALU_OUT_WIDTH-1 -: HI_WIDTH]);
               tx_valid_d    = 1'b1;
               clk_gate_en_d = 1'b0;
               rd_path_d     = 1'b0;
               state_d       = TX_LO;
            end
         end
         TX_LO: begin
            // read replies are a single byte; ALU results continue with the high byte
            cmd_err_d = bus.rx_valid;
            if (tx_accept_c) begin
               if (rd_path_q) begin
                  tx_valid_d = 1'b0;
                  state_d    = IDLE;
               end else begin
                  tx_data_d = alu_hi_q;
                  state_d   = TX_HI;
               end
            end
         end
         TX_HI: begin
            cmd_err_d = bus.rx_valid;
            if (tx_accept_c) begin
               tx_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rf_wr_en    = rf_wr_en_q;
   assign bus.rf_rd_en    = rf_rd_en_q;
   assign bus.rf_addr     = rf_addr_q;
   assign bus.rf_wr_data  = rf_wr_data_q;
   assign bus.alu_en      = alu_en_q;
   assign bus.alu_fun     = alu_fun_q;
   assign bus.clk_gate_en = clk_gate_en_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: command-level model with expectation queues, register-file
// and ALU responders, and a per-cycle compare process.
module tb_sys_cmd_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned OW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sys_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW)) bus ();

   sys_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW)) dut (
      .ref_clk (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- command-level model ----------------
   logic [7:0]  rf_model [16];
   logic [11:0] exp_wr_q [$];
   logic [3:0]  exp_rd_q [$];
   logic [3:0]  exp_alu_q[$];
   logic [7:0]  exp_tx_q [$];
   logic [7:0]  tx_hist  [$];
   int          exp_err = 0;
   int          obs_err = 0;
   int          acc_cnt = 0;
   int          stall_cnt = 0;
   logic [3:0]  last_wr_addr, last_rd_addr, last_alu_fun;
   logic [7:0]  last_wr_data;

   function automatic logic [15:0] alu_model(input logic [3:0] fun, input logic [7:0] a,
                                             input logic [7:0] b);
      case (fun)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      exp_wr_q.push_back({a, d});
      rf_model[a] = d;
      send_byte(8'hAA); send_byte({4'h0, a}); send_byte(d);
   endtask

   task automatic do_read(input logic [3:0] a);
      exp_rd_q.push_back(a);
      exp_tx_q.push_back(rf_model[a]);
      send_byte(8'hBB); send_byte({4'h0, a});
   endtask

   task automatic expect_alu(input logic [3:0] fun);
      logic [15:0] r;
      r = alu_model(fun, rf_model[0], rf_model[1]);
      exp_alu_q.push_back(fun);
      exp_tx_q.push_back(r[7:0]);
      exp_tx_q.push_back(r[15:8]);
   endtask

   task automatic do_alu_ops(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
      exp_wr_q.push_back({4'h0, a});
      exp_wr_q.push_back({4'h1, b});
      rf_model[0] = a;
      rf_model[1] = b;
      expect_alu(fun);
      send_byte(8'hCC); send_byte(a); send_byte(b); send_byte({4'h0, fun});
   endtask

   task automatic do_alu(input logic [3:0] fun);
      expect_alu(fun);
      send_byte(8'hDD); send_byte({4'h0, fun});
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0 && exp_alu_q.size() == 0 &&
             exp_tx_q.size() == 0 && !bus.tx_valid) break;
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_drained"}, 32'(exp_wr_q.size() + exp_rd_q.size() + exp_alu_q.size() +
                                 exp_tx_q.size()), 32'd0);
      chk({tag, "_tx_idle"}, 32'(bus.tx_valid), 32'd0);
      chk({tag, "_cmd_err_count"}, 32'(obs_err), 32'(exp_err));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_strobes"}, 32'({bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.clk_gate_en,
                                  bus.tx_valid, bus.cmd_err}), 32'd0);
      chk({tag, "_rf_addr"}, 32'(bus.rf_addr), 32'd0);
      chk({tag, "_rf_wr_data"}, 32'(bus.rf_wr_data), 32'd0);
      chk({tag, "_alu_fun"}, 32'(bus.alu_fun), 32'd0);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
   endtask

   // ---------------- responders ----------------
   // register file: returns model contents two cycles after a read strobe
   initial begin : rf_resp
      logic [3:0] a;
      bus.rf_rd_data  = '0;
      bus.rf_rd_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rf_rd_en) begin
            a = bus.rf_addr;
            repeat (2) @(posedge clk);
            #1;
            bus.rf_rd_data  = rf_model[a];
            bus.rf_rd_valid = 1'b1;
            @(posedge clk); #1;
            bus.rf_rd_valid = 1'b0;
         end
      end
   end

   // ALU: computes on model operands and answers four cycles after alu_en
   initial begin : alu_resp
      logic [3:0] f;
      bus.alu_out       = '0;
      bus.alu_out_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.alu_en) begin
            f = bus.alu_fun;
            repeat (4) @(posedge clk);
            #1;
            bus.alu_out       = alu_model(f, rf_model[0], rf_model[1]);
            bus.alu_out_valid = 1'b1;
            @(posedge clk); #1;
            bus.alu_out_valid = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   logic       gate_pend  = 1'b0;
   logic       prev_err   = 1'b0;

   always @(negedge clk) begin : cmp
      logic [11:0] ew;
      if (!rst_n) begin
         prev_stall = 1'b0;
         gate_pend  = 1'b0;
         prev_err   = 1'b0;
      end else begin
         if (bus.rf_wr_en || bus.rf_rd_en || bus.alu_en)
            chk("strobe_exclusive", 32'($countones({bus.rf_wr_en, bus.rf_rd_en, bus.alu_en})),
                32'd1);
         if (bus.rf_wr_en) begin
            chk("rf_write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
               ew = exp_wr_q.pop_front();
               chk("rf_write", 32'({bus.rf_addr, bus.rf_wr_data}), 32'(ew));
            end
            last_wr_addr = bus.rf_addr;
            last_wr_data = bus.rf_wr_data;
         end
         if (bus.rf_rd_en) begin
            chk("rf_read_expected", 32'(exp_rd_q.size() != 0), 32'd1);
            if (exp_rd_q.size() != 0) chk("rf_read_addr", 32'(bus.rf_addr), 32'(exp_rd_q.pop_front()));
            last_rd_addr = bus.rf_addr;
         end
         if (bus.alu_en) begin
            chk("alu_expected", 32'(exp_alu_q.size() != 0), 32'd1);
            if (exp_alu_q.size() != 0) chk("alu_fun", 32'(bus.alu_fun), 32'(exp_alu_q.pop_front()));
            last_alu_fun = bus.alu_fun;
         end
         chk("clk_gate_en", 32'(bus.clk_gate_en), 32'(gate_pend || bus.alu_en));
         if (bus.alu_en) gate_pend = 1'b1;
         if (bus.alu_out_valid) gate_pend = 1'b0;
         if (bus.cmd_err) begin
            obs_err++;
            chk("cmd_err_single_cycle", 32'(prev_err), 32'd0);
         end
         prev_err = bus.cmd_err;
         if (prev_stall) begin
            chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
            chk("tx_hold_data", 32'(bus.tx_data), 32'(prev_data));
         end
         if (bus.tx_valid && !bus.tx_full) begin
            chk("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
            if (exp_tx_q.size() != 0) chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx_q.pop_front()));
            tx_hist.push_back(bus.tx_data);
            acc_cnt++;
         end
         if (bus.tx_valid && bus.tx_full) stall_cnt++;
         prev_stall = bus.tx_valid && bus.tx_full;
         prev_data  = bus.tx_data;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int acc0, st0, err0, n;
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.tx_full  = 1'b0;
      rst_n        = 1'b0;
      for (int i = 0; i < 16; i++) rf_model[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // write AA,05,77
      acc0 = acc_cnt;
      do_write(4'h5, 8'h77);
      wait_done("write");
      chk("write_addr_lit", 32'(last_wr_addr), 32'h5);
      chk("write_data_lit", 32'(last_wr_data), 32'h77);
      chk("write_no_tx", 32'(acc_cnt - acc0), 32'd0);

      // read BB,02 returning 0x5A
      rf_model[2] = 8'h5A;
      acc0 = acc_cnt;
      do_read(4'h2);
      wait_done("read");
      chk("read_addr_lit", 32'(last_rd_addr), 32'h2);
      chk("read_tx_lit", 32'(tx_hist[tx_hist.size()-1]), 32'h5A);
      chk("read_one_byte", 32'(acc_cnt - acc0), 32'd1);

      // CC,05,03,01 -> 5-3 = 0x0002
      do_alu_ops(8'h05, 8'h03, 4'h1);
      wait_done("alu_ops");
      n = tx_hist.size();
      chk("alu_fun_lit", 32'(last_alu_fun), 32'h1);
      chk("alu_tx_lo_lit", 32'(tx_hist[n-2]), 32'h02);
      chk("alu_tx_hi_lit", 32'(tx_hist[n-1]), 32'h00);
      chk("alu_opb_lit", 32'({last_wr_addr, last_wr_data}), 32'h103);
      chk("alu_gate_off", 32'(bus.clk_gate_en), 32'd0);

      // DD,01 with TX FIFO full for 10 cycles at the first result byte
      acc0 = acc_cnt;
      st0  = stall_cnt;
      do_alu(4'h1);
      bus.tx_full = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (bus.tx_valid) break;
         @(posedge clk); #1;
      end
      chk("stall_tx_seen", 32'(bus.tx_valid), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      bus.tx_full = 1'b0;
      wait_done("stall");
      chk("stall_accepted_lit", 32'(acc_cnt - acc0), 32'd2);
      chk("stall_cycles_lit", 32'(stall_cnt - st0), 32'd10);
      chk("stall_lo_lit", 32'(tx_hist[tx_hist.size()-2]), 32'h02);

      // unknown byte in IDLE, then a stray byte during ALU_WAIT
      err0 = obs_err;
      exp_err++;
      send_byte(8'h12);
      wait_done("bad_cmd");
      do_alu(4'h2);
      exp_err++;
      send_byte(8'h55);
      wait_done("busy_byte");
      chk("err_pulses_lit", 32'(obs_err - err0), 32'd2);
      chk("mul_lo_lit", 32'(tx_hist[tx_hist.size()-2]), 32'h0F);

      // read-back of the first write and an add with a carry into the high byte
      do_read(4'h5);
      wait_done("read5");
      chk("read5_lit", 32'(tx_hist[tx_hist.size()-1]), 32'h77);
      do_alu_ops(8'hF0, 8'h20, 4'h0);
      wait_done("add");
      chk("add_hi_lit", 32'(tx_hist[tx_hist.size()-1]), 32'h01);
      chk("add_lo_lit", 32'(tx_hist[tx_hist.size()-2]), 32'h10);

      // reset in the middle of CC,05,...
      exp_wr_q.push_back({4'h0, 8'h05});
      rf_model[0] = 8'h05;
      send_byte(8'hCC);
      send_byte(8'h05);
      repeat (2) @(posedge clk);
      #1;
      chk("pre_reset_wdata", 32'(bus.rf_wr_data), 32'h05);
      rst_n = 1'b0;
      #1;
      chk_zero("mid_reset");
      repeat (2) @(posedge clk);
      #1;
      chk_zero("mid_reset_hold");
      rst_n = 1'b1;
      do_write(4'h3, 8'h11);
      wait_done("post_reset");
      chk("post_reset_addr_lit", 32'(last_wr_addr), 32'h3);
      chk("post_reset_data_lit", 32'(last_wr_data), 32'h11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sys_cmd_ctrl.md
SYS_CMD_CTRL -- requirements
Module: sys_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning command/data byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width.
REQ-003 SHALL have parameter ALU_OUT_WIDTH, default 16, meaning ALU result width (2*DATA_WIDTH).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: ports ref_clk and reset_n.
REQ-005 ref_clk  input  1  system clock; all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 rx_data  input  DATA_WIDTH  received UART byte (already synchronised to ref_clk).
REQ-008 rx_valid  input  1  one-cycle pulse; rx_data valid.
REQ-009 rf_wr_en / rf_rd_en  output  1 each  register-file write / read strobe.
REQ-010 rf_addr  output  ADDR_WIDTH  register-file address.
REQ-011 rf_wr_data  output  DATA_WIDTH  register-file write data.
REQ-012 rf_rd_data / rf_rd_valid  input  DATA_WIDTH / 1  read data and its valid pulse.
REQ-013 alu_en / alu_fun  output  1 / 4  ALU enable and function code.
REQ-014 clk_gate_en  output  1  ALU clock-gate enable.
REQ-015 alu_out / alu_out_valid  input  ALU_OUT_WIDTH / 1  ALU result and its valid pulse.
REQ-016 tx_data / tx_valid  output  DATA_WIDTH / 1  byte toward TX FIFO.
REQ-017 tx_full  input  1  TX FIFO full.
REQ-018 cmd_err  output  1  one-cycle pulse on unknown command or dropped byte.

Function
REQ-019 SHALL decode command bytes in IDLE: 0xAA write, 0xBB read, 0xCC ALU-with-operands, 0xDD ALU-no-operands; any other byte SHALL pulse cmd_err and remain in IDLE.
REQ-020 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
REQ-021 Write: WR_ADDR latches rx_data[ADDR_WIDTH-1:0]; on the WR_DATA byte, rf_wr_en SHALL pulse one cycle with latched address and that byte, next state IDLE.
REQ-022 Read: on the RD_ADDR byte, rf_rd_en SHALL pulse one cycle with that address, then RD_WAIT; on rf_rd_valid, rf_rd_data goes to tx_data in TX_LO; after acceptance, return to IDLE (no TX_HI).
REQ-023 ALU_A byte SHALL be written to rf address 0; ALU_B byte to rf address 1 (rf_wr_en one-cycle pulse each); then ALU_FUN.
REQ-024 0xDD SHALL go directly to ALU_FUN.
REQ-025 On the ALU_FUN byte: alu_fun <= rx_data[3:0]; alu_en SHALL pulse one cycle; clk_gate_en SHALL assert in the same cycle and hold through ALU_WAIT; then ALU_WAIT.
REQ-026 On alu_out_valid in ALU_WAIT: latch alu_out, deassert clk_gate_en, send alu_out[7:0] (TX_LO) then alu_out[15:8] (TX_HI), then IDLE.
REQ-027 TX handshake: tx_valid held with stable tx_data until a cycle with tx_valid=1 and tx_full=0 (byte accepted); tx_valid SHALL drop or advance the next cycle; no byte lost or duplicated while tx_full=1.
REQ-028 rx_valid in RD_WAIT, ALU_WAIT, TX_LO, TX_HI SHALL be dropped with a cmd_err pulse; state unchanged.
REQ-029 rf_wr_en, rf_rd_en and alu_en SHALL never assert in the same cycle.
REQ-030 Strobes SHALL be registered outputs; first strobe appears the cycle after the triggering rx_valid.

Reset
REQ-031 reset_n low SHALL immediately force IDLE and all outputs to 0 (rf_addr, rf_wr_data, alu_fun, tx_data = 0), including mid-command; partial frames SHALL be discarded.
REQ-032 After reset release, the first byte SHALL be treated as a command byte.

Verification
REQ-033 Bytes AA,05,77 -> single rf_wr_en pulse, rf_addr=5, rf_wr_data=0x77; no tx_valid.
REQ-034 Bytes BB,02; model returns 0x5A -> rf_rd_en pulse addr 2, then tx_data=0x5A accepted once.
REQ-035 Bytes CC,05,03,01; ALU returns 0x0002 -> writes addr0=0x05, addr1=0x03, alu_en with alu_fun=1, tx bytes 0x02 then 0x00, clk_gate_en low after.
REQ-036 Bytes DD,01 with tx_full held high 10 cycles during TX_LO -> tx_data stable, exactly two bytes accepted after release.
REQ-037 Byte 0x12 in IDLE, and a byte sent during ALU_WAIT -> one cmd_err pulse each, no strobes.
REQ-038 reset_n low after CC,05 -> all outputs 0; next AA,03,11 -> write addr 3 data 0x11 correct.
